pe_palette_arbiter: RTL and testbench

//  Shares the single-port palette RAM between the priority-evaluation pipeline (PE) and the CPU bus.
//  PE issues palette reads in fixed phases of its 4-cycle per-pixel schedule and is real-time.
//  The CPU issues reads and writes.
//  PE wins by default; a starvation counter guarantees the CPU a slot within MAX_WAIT cycles.

---
 rtl/pe_palette_arbiter.sv | 169 ++++++++++++++++
 tb/tb_pe_palette_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_palette_arbiter.sv
// Arbitrates the single-port palette RAM between the real-time PE read pipeline and the CPU bus.
// The PE wins by default. A starvation counter forces a CPU slot, and read returns are steered by an owner tag.
module pe_palette_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pe_req,
    input  logic [ADDR_W-1:0] pe_addr,
    output logic              pe_ack,
    output logic              pe_rvalid,
    output logic [DATA_W-1:0] pe_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              pe_stall,
    output logic              pe_overrun
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PE   = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic              grant_pe_s;
    logic              grant_cpu_s;
    logic [3:0]        wait_cnt_r;
    owner_t            owner_r;
    logic [DATA_W-1:0] pe_hold_r;
    logic [DATA_W-1:0] cpu_hold_r;
    logic              pe_stall_r;
    logic              pe_overrun_r;

    // Grant decision: a starved CPU beats the PE, otherwise the PE has priority.
    // No grant is issued while reset is held, so the RAM is never strobed during reset.
    always_comb begin
        grant_pe_s  = 1'b0;
        grant_cpu_s = 1'b0;
        if (reset) begin
            grant_pe_s  = 1'b0;
            grant_cpu_s = 1'b0;
        end else if (cpu_req && (wait_cnt_r == WAIT_LIMIT)) begin
            grant_cpu_s = 1'b1;
        end else if (pe_req) begin
            grant_pe_s = 1'b1;
        end else if (cpu_req) begin
            grant_cpu_s = 1'b1;
        end else begin
            grant_pe_s  = 1'b0;
            grant_cpu_s = 1'b0;
        end
    end

    assign pe_ack  = grant_pe_s;
    assign cpu_ack = grant_cpu_s;

    // RAM port mux: the PE only ever reads, and the CPU passes through. An idle port is driven to zero.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        if (grant_pe_s) begin
            ram_en   = 1'b1;
            ram_addr = pe_addr;
        end else if (grant_cpu_s) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else begin
            ram_en = 1'b0;
        end
    end

    // Starvation counter: counts consecutive denied CPU cycles and saturates at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (!cpu_req || grant_cpu_s) begin
            wait_cnt_r <= 4'd0;
        end else if (wait_cnt_r < WAIT_LIMIT) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Owner tag: records who owns the read data that the RAM returns next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_r <= OWN_NONE;
        end else if (grant_pe_s) begin
            owner_r <= OWN_PE;
        end else if (grant_cpu_s && !cpu_we) begin
            owner_r <= OWN_CPU;
        end else begin
            owner_r <= OWN_NONE;
        end
    end

    // Last-delivered data per requester, so the non-owner's rdata holds steady.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pe_hold_r  <= {DATA_W{1'b0}};
            cpu_hold_r <= {DATA_W{1'b0}};
        end else begin
            case (owner_r)
                OWN_PE:  pe_hold_r  <= ram_rdata;
                OWN_CPU: cpu_hold_r <= ram_rdata;
                default: begin
                    pe_hold_r  <= pe_hold_r;
                    cpu_hold_r <= cpu_hold_r;
                end
            endcase
        end
    end

    // Return steering: the tagged requester sees the live RAM data, and the other sees its held value.
    always_comb begin
        pe_rvalid  = 1'b0;
        cpu_rvalid = 1'b0;
        pe_rdata   = pe_hold_r;
        cpu_rdata  = cpu_hold_r;
        case (owner_r)
            OWN_PE: begin
                pe_rvalid = 1'b1;
                pe_rdata  = ram_rdata;
            end
            OWN_CPU: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = ram_rdata;
            end
            default: begin
                pe_rvalid  = 1'b0;
                cpu_rvalid = 1'b0;
            end
        endcase
    end

    // PE denial flags: a one-cycle-late stall pulse and a sticky overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pe_stall_r   <= 1'b0;
            pe_overrun_r <= 1'b0;
        end else begin
            pe_stall_r   <= pe_req && !grant_pe_s;
            pe_overrun_r <= pe_overrun_r | (pe_req && !grant_pe_s);
        end
    end

    assign pe_stall   = pe_stall_r;
    assign pe_overrun = pe_overrun_r;

endmodule

// File: tb/tb_pe_palette_arbiter.sv
// Table-driven bench for pe_palette_arbiter with a behavioural palette RAM.
// It uses a scoreboard queue of expected read returns.
module tb_pe_palette_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_PE   = 2'd1;
    localparam logic [1:0] K_CPU  = 2'd2;

    typedef struct packed {
        logic              pe_req;
        logic [ADDR_W-1:0] pe_addr;
        logic              cpu_req;
        logic              cpu_we;
        logic [ADDR_W-1:0] cpu_addr;
        logic [DATA_W-1:0] cpu_wdata;
        logic              exp_pe_ack;
        logic              exp_cpu_ack;
    } vec_t;

    typedef struct packed {
        logic [1:0]        kind;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              pe_req;
    logic [ADDR_W-1:0] pe_addr;
    logic              pe_ack;
    logic              pe_rvalid;
    logic [DATA_W-1:0] pe_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              pe_stall;
    logic              pe_overrun;

    logic              ram_load;
    logic [DATA_W-1:0] mem    [512];
    logic [DATA_W-1:0] shadow [512];

    int                n_checks = 0;
    int                n_fail   = 0;
    string             tag;
    ret_t              ret_q[$];
    logic [DATA_W-1:0] last_pe;
    logic [DATA_W-1:0] last_cpu;
    logic              exp_stall;
    logic              exp_ovr;
    vec_t              tbl[11];

    pe_palette_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(3)) dut (
        .clock(clock), .reset(reset),
        .pe_req(pe_req), .pe_addr(pe_addr), .pe_ack(pe_ack),
        .pe_rvalid(pe_rvalid), .pe_rdata(pe_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pe_stall(pe_stall), .pe_overrun(pe_overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return {a[6:0], a} ^ 16'h5A5A;
    endfunction

    // Palette RAM model: read data is registered, and writes land at the clock edge.
    always @(posedge clock) begin
        if (ram_load) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val(9'(i));
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    function automatic vec_t mk(input logic pr, input logic [ADDR_W-1:0] pa, input logic cr,
                                input logic cw, input logic [ADDR_W-1:0] ca,
                                input logic [DATA_W-1:0] cd, input logic ep, input logic ec);
        vec_t v;
        v.pe_req = pr; v.pe_addr = pa; v.cpu_req = cr; v.cpu_we = cw;
        v.cpu_addr = ca; v.cpu_wdata = cd; v.exp_pe_ack = ep; v.exp_cpu_ack = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, name, act, exp);
        end
    endtask

    task automatic check_all_zero();
        chk("pe_ack", 32'(pe_ack), 32'd0);
        chk("cpu_ack", 32'(cpu_ack), 32'd0);
        chk("pe_rvalid", 32'(pe_rvalid), 32'd0);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("pe_rdata", 32'(pe_rdata), 32'd0);
        chk("cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("ram_en", 32'(ram_en), 32'd0);
        chk("ram_we", 32'(ram_we), 32'd0);
        chk("ram_addr", 32'(ram_addr), 32'd0);
        chk("ram_wdata", 32'(ram_wdata), 32'd0);
        chk("pe_stall", 32'(pe_stall), 32'd0);
        chk("pe_overrun", 32'(pe_overrun), 32'd0);
    endtask

    // Drive one cycle. At the falling edge it checks the return due from the last grant and this cycle's grant, then queues the next return.
    task automatic apply(input vec_t v);
        ret_t              e;
        logic [ADDR_W-1:0] ea;
        pe_req = v.pe_req; pe_addr = v.pe_addr;
        cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
        @(negedge clock);
        if (ret_q.size() > 0) e = ret_q.pop_front();
        else e = '{kind: K_NONE, data: 16'h0000};
        if (e.kind == K_PE)  last_pe  = e.data;
        if (e.kind == K_CPU) last_cpu = e.data;
        chk("pe_rvalid", 32'(pe_rvalid), 32'(e.kind == K_PE));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.kind == K_CPU));
        chk("pe_rdata", 32'(pe_rdata), 32'(last_pe));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(last_cpu));
        chk("pe_stall", 32'(pe_stall), 32'(exp_stall));
        chk("pe_overrun", 32'(pe_overrun), 32'(exp_ovr));
        chk("pe_ack", 32'(pe_ack), 32'(v.exp_pe_ack));
        chk("cpu_ack", 32'(cpu_ack), 32'(v.exp_cpu_ack));
        chk("ram_en", 32'(ram_en), 32'(v.exp_pe_ack | v.exp_cpu_ack));
        chk("ram_we", 32'(ram_we), 32'(v.exp_cpu_ack & v.cpu_we));
        ea = v.exp_pe_ack ? v.pe_addr : (v.exp_cpu_ack ? v.cpu_addr : 9'h000);
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        if (!v.exp_pe_ack)
            chk("ram_wdata", 32'(ram_wdata), 32'(v.exp_cpu_ack ? v.cpu_wdata : 16'h0000));
        if (v.exp_pe_ack)
            ret_q.push_back('{kind: K_PE, data: shadow[v.pe_addr]});
        else if (v.exp_cpu_ack && !v.cpu_we)
            ret_q.push_back('{kind: K_CPU, data: shadow[v.cpu_addr]});
        else
            ret_q.push_back('{kind: K_NONE, data: 16'h0000});
        if (v.exp_cpu_ack && v.cpu_we) shadow[v.cpu_addr] = v.cpu_wdata;
        exp_stall = v.pe_req && !v.exp_pe_ack;
        exp_ovr   = exp_ovr | exp_stall;
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) shadow[i] = init_val(9'(i));
        last_pe = 16'h0000; last_cpu = 16'h0000; exp_stall = 1'b0; exp_ovr = 1'b0;
        reset = 1'b1; ram_load = 1'b1;
        pe_req = 1'b0; pe_addr = 9'h000; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 9'h000; cpu_wdata = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        ram_load = 1'b0;
        tag = "reset";
        @(negedge clock);
        check_all_zero();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single-requester reads and writes, including address and data extremes.
        tbl[0]  = mk(1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0);
        tbl[1]  = mk(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 9'h000, 1'b1, 1'b1, 9'h1FF, 16'h7FFF, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 9'h000, 1'b1, 1'b0, 9'h1FF, 16'h0000, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b1);
        tbl[6]  = mk(1'b1, 9'h1FF, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 9'h000, 1'b1, 1'b1, 9'h010, 16'h1234, 1'b0, 1'b1);
        tbl[8]  = mk(1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            tag = $sformatf("table[%0d]", i);
            apply(tbl[i]);
        end

        // PE requests 2 of every 4 cycles while the CPU always requests, so the CPU fills every gap.
        for (int i = 0; i < 16; i++) begin
            tag = $sformatf("phase4[%0d]", i);
            apply(mk((i % 4) < 2, 9'(i * 3), 1'b1, 1'b0, 9'(9'h100 + i / 4), 16'h0000,
                     (i % 4) < 2, (i % 4) >= 2));
        end

        // PE and CPU reads alternate cycle by cycle, and each return must reach its own requester.
        for (int i = 0; i < 12; i++) begin
            tag = $sformatf("alt[%0d]", i);
            if (i % 2 == 0)
                apply(mk(1'b1, 9'(9'h020 + i), 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0));
            else
                apply(mk(1'b0, 9'h000, 1'b1, 1'b0, 9'(9'h180 + i), 16'h0000, 1'b0, 1'b1));
        end

        // Both sides request continuously: three PE grants, then one forced CPU grant, in a repeating pattern.
        for (int i = 0; i < 16; i++) begin
            tag = $sformatf("contend[%0d]", i);
            apply(mk(1'b1, 9'h040, 1'b1, 1'b0, 9'(9'h1F0 + i / 4), 16'h0000,
                     (i % 4) != 3, (i % 4) == 3));
        end

        // Reset lands while a PE read return is in flight, and the return must be dropped.
        tag = "pre_reset";
        apply(mk(1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0));
        reset = 1'b1;
        pe_req = 1'b0;
        tag = "mid_reset";
        @(negedge clock);
        check_all_zero();
        ret_q.delete();
        last_pe = 16'h0000; last_cpu = 16'h0000; exp_stall = 1'b0; exp_ovr = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tag = "post_reset0";
        apply(mk(1'b1, 9'h1FF, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 1'b0));
        tag = "post_reset1";
        apply(mk(1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
